// File: rtl/barrel_shift.sv
// 32-bit, five-stage pipelined barrel shifter: logical shift left or rotate left by 0-31.
// Each stage handles one shift-amount bit (16, 8, 4, 2, 1) and carries the remaining bits and rot.
module barrel_shift (
   input  logic [31:0] a,
   input  logic [4:0]  shift,
   input  logic        rot,
   output logic [31:0] out,
   input  logic        clk,
   input  logic        rst_n
);

   localparam int unsigned W = 32;

   // Shift or rotate left by a fixed amount when en is set; zero fill unless rotating.
   function automatic logic [W-1:0] stage_fn(input logic [W-1:0] d, input logic en,
                                             input logic r, input int unsigned amt);
      logic [W-1:0] res;
      res = d << amt;
      if (r) res = res | (d >> (W - amt));
      return en ? res : d;
   endfunction

   logic [W-1:0] d1_q, d1_d, d2_q, d2_d, d3_q, d3_d, d4_q, d4_d, d5_q, d5_d;
   logic [3:0]   sh1_q, sh1_d;
   logic [2:0]   sh2_q, sh2_d;
   logic [1:0]   sh3_q, sh3_d;
   logic         sh4_q, sh4_d;
   logic         rot1_q, rot1_d, rot2_q, rot2_d, rot3_q, rot3_d, rot4_q, rot4_d;

   always_comb begin
      d1_d   = stage_fn(a,    shift[4], rot,    16);
      sh1_d  = shift[3:0];
      rot1_d = rot;

      d2_d   = stage_fn(d1_q, sh1_q[3], rot1_q, 8);
      sh2_d  = sh1_q[2:0];
      rot2_d = rot1_q;

      d3_d   = stage_fn(d2_q, sh2_q[2], rot2_q, 4);
      sh3_d  = sh2_q[1:0];
      rot3_d = rot2_q;

      d4_d   = stage_fn(d3_q, sh3_q[1], rot3_q, 2);
      sh4_d  = sh3_q[0];
      rot4_d = rot3_q;

      // Last stage consumes the final amount bit, so only data remains to register.
      d5_d   = stage_fn(d4_q, sh4_q,    rot4_q, 1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d1_q   <= '0;
         d2_q   <= '0;
         d3_q   <= '0;
         d4_q   <= '0;
         d5_q   <= '0;
         sh1_q  <= '0;
         sh2_q  <= '0;
         sh3_q  <= '0;
         sh4_q  <= 1'b0;
         rot1_q <= 1'b0;
         rot2_q <= 1'b0;
         rot3_q <= 1'b0;
         rot4_q <= 1'b0;
      end else begin
         d1_q   <= d1_d;
         d2_q   <= d2_d;
         d3_q   <= d3_d;
         d4_q   <= d4_d;
         d5_q   <= d5_d;
         sh1_q  <= sh1_d;
         sh2_q  <= sh2_d;
         sh3_q  <= sh3_d;
         sh4_q  <= sh4_d;
         rot1_q <= rot1_d;
         rot2_q <= rot2_d;
         rot3_q <= rot3_d;
         rot4_q <= rot4_d;
      end
   end

   assign out = d5_q;

endmodule

// File: tb/tb_barrel_shift.sv
// Bench for barrel_shift: directed cases, random back-to-back stream, mid-stream reset, walking one.
module tb_barrel_shift;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] a;
   logic [4:0]  shift;
   logic        rot;
   logic [31:0] out;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];
   string       tag_q[$];

   always #5 clk = ~clk;

   barrel_shift dut (
      .a     (a),
      .shift (shift),
      .rot   (rot),
      .out   (out),
      .clk   (clk),
      .rst_n (rst_n)
   );

   // Rotate: upper half of a doubled word shifted left; shift: lower half of a zero-extended word.
   function automatic logic [31:0] ref_model(input logic [31:0] x, input logic [4:0] s, input logic r);
      logic [63:0] w;
      if (r) begin
         w = {x, x} << s;
         return w[63:32];
      end
      w = {32'd0, x} << s;
      return w[31:0];
   endfunction

   task automatic check(input string tag, input logic [31:0] expv);
      checks++;
      assert (out === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, out, expv);
      end
   endtask

   // Drive one operand set, sample it on the next edge, then check whatever emerges now.
   task automatic step(input string tag, input logic [31:0] av, input logic [4:0] sv,
                       input logic rv, input logic [31:0] ev);
      a     = av;
      shift = sv;
      rot   = rv;
      @(posedge clk);
      exp_q.push_back(ev);
      tag_q.push_back(tag);
      #1;
      if (exp_q.size() == 5) check(tag_q.pop_front(), exp_q.pop_front());
   endtask

   // After reset the four older stages hold zeros, so out must read 0 until new data emerges.
   task automatic preload_zeros();
      exp_q = {};
      tag_q = {};
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(32'd0);
         tag_q.push_back("post_reset_zero");
      end
   endtask

   initial begin
      logic [31:0] ra;
      logic [4:0]  rs;
      logic        rr;

      rst_n = 1'b0;
      a     = 32'hDEAD_BEEF;
      shift = 5'd7;
      rot   = 1'b1;
      #12;
      check("reset_out", 32'd0);
      @(posedge clk);
      #1;
      check("reset_held_out", 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      preload_zeros();

      step("shift_4",      32'h00FF_00FF, 5'd4,  1'b0, 32'h0FF0_0FF0);
      step("rotate_4",     32'hF3FF_00FF, 5'd4,  1'b1, 32'h3FF0_0FFF);
      step("shift0_rot0",  32'h8000_0001, 5'd0,  1'b0, 32'h8000_0001);
      step("shift0_rot1",  32'h8000_0001, 5'd0,  1'b1, 32'h8000_0001);
      step("shift31_rot0", 32'h8000_0001, 5'd31, 1'b0, 32'h8000_0000);
      step("shift31_rot1", 32'h8000_0001, 5'd31, 1'b1, 32'hC000_0000);

      for (int i = 0; i < 1000; i++) begin
         ra = $urandom;
         rs = 5'($urandom_range(31, 0));
         rr = 1'($urandom_range(1, 0));
         step("random", ra, rs, rr, ref_model(ra, rs, rr));
      end

      // Three operands in flight when reset hits between edges.
      for (int i = 0; i < 3; i++) begin
         ra = $urandom | 32'h0000_0001;
         step("pre_reset", ra, 5'd0, 1'b1, ra);
      end
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_out", 32'd0);
      @(posedge clk);
      #1;
      check("reset_mid_held", 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      preload_zeros();

      step("after_reset", 32'h1234_5678, 5'd8, 1'b1, 32'h3456_7812);
      step("after_reset_shift", 32'h1234_5678, 5'd8, 1'b0, 32'h3456_7800);

      for (int s = 0; s < 32; s++)
         step("walking_one", 32'h0000_0001, 5'(s), 1'b1, 32'd1 << s);

      for (int i = 0; i < 4; i++)
         step("drain", 32'd0, 5'd0, 1'b0, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
